// File: rtl/decode_stage_rv32_if.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_rv32_if
//  Purpose  : Fetch-to-decode instruction handshake (valid/ready, PC, word).
//  Revision : 1.0  initial release
// ============================================================================
interface decode_stage_rv32_if #(
    parameter int XLEN = 32
) ();
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic [XLEN-1:0] f_instr;
    logic            f_ready;

    modport master (output f_valid, f_pc, f_instr, input f_ready);
    modport slave  (input f_valid, f_pc, f_instr, output f_ready);
endinterface
`default_nettype wire

// File: rtl/decode_stage_rv32.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage_rv32
//  Purpose  : RV32IM+Zicsr decode: immediates, forwarded operands, load-use
//             hazard, registered into the execute pipeline slot.
//  Revision : 1.0  initial release
// ============================================================================
module decode_stage_rv32 #(
    parameter int XLEN     = 32,
    parameter int ECAUSE_W = 4
) (
    input  wire logic                clk,
    input  wire logic                rst,
    decode_stage_rv32_if.slave       fetch,
    output logic [4:0]               rf_raddr1,
    output logic [4:0]               rf_raddr2,
    input  wire logic [XLEN-1:0]     rf_rdata1,
    input  wire logic [XLEN-1:0]     rf_rdata2,
    input  wire logic                ex_stall,
    input  wire logic                ex_clear,
    input  wire logic                ex_load,
    input  wire logic [4:0]          ex_waddr,
    input  wire logic                fw_wren,
    input  wire logic [4:0]          fw_waddr,
    input  wire logic [XLEN-1:0]     fw_wdata,
    output logic                     d_valid,
    output logic [XLEN-1:0]          d_pc,
    output logic [XLEN-1:0]          d_npc,
    output logic [XLEN-1:0]          d_imm,
    output logic [XLEN-1:0]          d_rdata1,
    output logic [XLEN-1:0]          d_rdata2,
    output logic [4:0]               d_waddr,
    output logic                     d_wren,
    output logic                     d_rden1,
    output logic                     d_rden2,
    output logic [13:0]              d_class,
    output logic [3:0]               d_alu_op,
    output logic                     d_exception,
    output logic [ECAUSE_W-1:0]      d_ecause
);

    localparam logic [6:0] c_OP_LUI    = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_IMM    = 7'b0010011;
    localparam logic [6:0] c_OP_REG    = 7'b0110011;
    localparam logic [6:0] c_OP_FENCE  = 7'b0001111;
    localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;

    localparam int c_CLS_LUI    = 13;
    localparam int c_CLS_AUIPC  = 12;
    localparam int c_CLS_JAL    = 11;
    localparam int c_CLS_JALR   = 10;
    localparam int c_CLS_BRANCH = 9;
    localparam int c_CLS_LOAD   = 8;
    localparam int c_CLS_STORE  = 7;
    localparam int c_CLS_CSR    = 6;
    localparam int c_CLS_MUL    = 5;
    localparam int c_CLS_DIV    = 4;
    localparam int c_CLS_FENCE  = 3;
    localparam int c_CLS_ECALL  = 2;
    localparam int c_CLS_EBREAK = 1;
    localparam int c_CLS_MRET   = 0;

    localparam logic [ECAUSE_W-1:0] c_CAUSE_ILLEGAL = ECAUSE_W'(2);
    localparam logic [ECAUSE_W-1:0] c_CAUSE_EBREAK  = ECAUSE_W'(3);
    localparam logic [ECAUSE_W-1:0] c_CAUSE_ECALL   = ECAUSE_W'(11);

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     npc;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     rdata1;
        logic [XLEN-1:0]     rdata2;
        logic [4:0]          waddr;
        logic                wren;
        logic                rden1;
        logic                rden2;
        logic [13:0]         cls;
        logic [3:0]          alu_op;
        logic                exc;
        logic [ECAUSE_W-1:0] ecause;
    } slot_t;

    slot_t slot_q, slot_d, w_dec;

    logic [XLEN-1:0]     w_instr;
    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    logic [6:0]          w_funct7;
    logic [4:0]          w_rd, w_rs1, w_rs2;
    logic [XLEN-1:0]     w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic                w_illegal, w_writes, w_rden1, w_rden2, w_alu7, w_exc, w_hz;
    logic [13:0]         w_cls;
    logic [XLEN-1:0]     w_imm;
    logic [ECAUSE_W-1:0] w_ecause;

    assign w_instr  = fetch.f_instr;
    assign w_opcode = w_instr[6:0];
    assign w_funct3 = w_instr[14:12];
    assign w_funct7 = w_instr[31:25];
    assign w_rd     = w_instr[11:7];
    assign w_rs1    = w_instr[19:15];
    assign w_rs2    = w_instr[24:20];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'h000};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    always_comb begin
        w_illegal = 1'b0;
        w_writes  = 1'b0;
        w_rden1   = 1'b0;
        w_rden2   = 1'b0;
        w_alu7    = 1'b0;
        w_exc     = 1'b0;
        w_cls     = '0;
        w_imm     = '0;
        w_ecause  = '0;
        case (w_opcode)
            c_OP_LUI:    begin w_cls[c_CLS_LUI] = 1'b1;   w_writes = 1'b1; w_imm = w_imm_u; end
            c_OP_AUIPC:  begin w_cls[c_CLS_AUIPC] = 1'b1; w_writes = 1'b1; w_imm = w_imm_u; end
            c_OP_JAL:    begin w_cls[c_CLS_JAL] = 1'b1;   w_writes = 1'b1; w_imm = w_imm_j; end
            c_OP_JALR: begin
                w_illegal = (w_funct3 != 3'b000);
                w_cls[c_CLS_JALR] = 1'b1;
                w_writes = 1'b1;
                w_rden1  = 1'b1;
                w_imm    = w_imm_i;
            end
            c_OP_BRANCH: begin
                w_illegal = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
                w_cls[c_CLS_BRANCH] = 1'b1;
                w_rden1 = 1'b1;
                w_rden2 = 1'b1;
                w_imm   = w_imm_b;
            end
            c_OP_LOAD: begin
                w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
                w_cls[c_CLS_LOAD] = 1'b1;
                w_writes = 1'b1;
                w_rden1  = 1'b1;
                w_imm    = w_imm_i;
            end
            c_OP_STORE: begin
                w_illegal = (w_funct3[2] || w_funct3[1:0] == 2'b11);
                w_cls[c_CLS_STORE] = 1'b1;
                w_rden1 = 1'b1;
                w_rden2 = 1'b1;
                w_imm   = w_imm_s;
            end
            c_OP_IMM: begin
                // Only the shift-immediates constrain funct7; SRAI alone carries bit 30 into alu_op.
                if (w_funct3 == 3'b001)
                    w_illegal = (w_funct7 != 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_illegal = (w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000);
                w_alu7   = (w_funct3 == 3'b101) && w_instr[30];
                w_writes = 1'b1;
                w_rden1  = 1'b1;
                w_imm    = w_imm_i;
            end
            c_OP_REG: begin
                w_writes = 1'b1;
                w_rden1  = 1'b1;
                w_rden2  = 1'b1;
                if (w_funct7 == 7'b0000001) begin
                    w_cls[c_CLS_DIV] = w_funct3[2];
                    w_cls[c_CLS_MUL] = ~w_funct3[2];
                end else if (w_funct7 == 7'b0100000) begin
                    w_illegal = (w_funct3 != 3'b000) && (w_funct3 != 3'b101);
                    w_alu7    = 1'b1;
                end else begin
                    w_illegal = (w_funct7 != 7'b0000000);
                end
            end
            c_OP_FENCE: begin
                w_illegal = (w_funct3 != 3'b000);
                w_cls[c_CLS_FENCE] = 1'b1;
            end
            c_OP_SYSTEM: begin
                if (w_funct3 == 3'b000) begin
                    if (w_rs1 != 5'd0 || w_rd != 5'd0) begin
                        w_illegal = 1'b1;
                    end else begin
                        case (w_instr[31:20])
                            12'h000: begin w_cls[c_CLS_ECALL] = 1'b1;  w_exc = 1'b1; w_ecause = c_CAUSE_ECALL;  end
                            12'h001: begin w_cls[c_CLS_EBREAK] = 1'b1; w_exc = 1'b1; w_ecause = c_CAUSE_EBREAK; end
                            12'h302: w_cls[c_CLS_MRET]  = 1'b1;
                            12'h105: w_cls[c_CLS_FENCE] = 1'b1;
                            default: w_illegal = 1'b1;
                        endcase
                    end
                end else if (w_funct3 == 3'b100) begin
                    w_illegal = 1'b1;
                end else begin
                    w_cls[c_CLS_CSR] = 1'b1;
                    w_writes = 1'b1;
                    w_rden1  = ~w_funct3[2];
                    w_imm    = w_imm_i;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_cls    = '0;
            w_writes = 1'b0;
            w_rden1  = 1'b0;
            w_rden2  = 1'b0;
            w_exc    = 1'b1;
            w_ecause = c_CAUSE_ILLEGAL;
        end
    end

    function automatic logic [XLEN-1:0] operand_sel(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs == 5'd0)
            return '0;
        else if (fw_wren && fw_waddr == rs)
            return fw_wdata;
        else
            return rf;
    endfunction

    assign rf_raddr1 = w_rs1;
    assign rf_raddr2 = w_rs2;

    assign w_hz = fetch.f_valid && ex_load && slot_q.valid && (ex_waddr != 5'd0) &&
                  ((w_rden1 && w_rs1 == ex_waddr) || (w_rden2 && w_rs2 == ex_waddr));

    assign fetch.f_ready = ex_clear || (!ex_stall && !w_hz);

    always_comb begin
        w_dec.valid  = 1'b1;
        w_dec.pc     = fetch.f_pc;
        w_dec.npc    = fetch.f_pc + XLEN'(4);
        w_dec.imm    = w_imm;
        w_dec.rdata1 = operand_sel(w_rs1, rf_rdata1);
        w_dec.rdata2 = operand_sel(w_rs2, rf_rdata2);
        w_dec.waddr  = w_rd;
        w_dec.wren   = w_writes && (w_rd != 5'd0) && !w_exc;
        w_dec.rden1  = w_rden1;
        w_dec.rden2  = w_rden2;
        w_dec.cls    = w_cls;
        w_dec.alu_op = {w_alu7, w_funct3};
        w_dec.exc    = w_exc;
        w_dec.ecause = w_ecause;

        slot_d = slot_q;
        if (ex_clear)
            slot_d = '0;
        else if (ex_stall)
            slot_d = slot_q;
        else if (w_hz || !fetch.f_valid)
            slot_d = '0;
        else
            slot_d = w_dec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    assign d_valid     = slot_q.valid;
    assign d_pc        = slot_q.pc;
    assign d_npc       = slot_q.npc;
    assign d_imm       = slot_q.imm;
    assign d_rdata1    = slot_q.rdata1;
    assign d_rdata2    = slot_q.rdata2;
    assign d_waddr     = slot_q.waddr;
    assign d_wren      = slot_q.wren;
    assign d_rden1     = slot_q.rden1;
    assign d_rden2     = slot_q.rden2;
    assign d_class     = slot_q.cls;
    assign d_alu_op    = slot_q.alu_op;
    assign d_exception = slot_q.exc;
    assign d_ecause    = slot_q.ecause;

endmodule
`default_nettype wire
